// File: rtl/lcd_stream_pkg.sv
// Shared types and constants for the LCD scanline streamer.
`timescale 1ns/1ps
package lcd_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LHDR,
    ST_LNUM,
    ST_LDATA,
    ST_FHDR,
    ST_FNUM
  } stream_state_t;

  localparam logic [7:0] LINE_HDR  = 8'hA5;
  localparam logic [7:0] FRAME_HDR = 8'h5A;

  localparam int LCD_WIDTH_DEFAULT  = 160;
  localparam int LCD_HEIGHT_DEFAULT = 144;
  localparam int BYTES_PER_LINE     = LCD_WIDTH_DEFAULT / 4;

  function automatic int idx_width(input int width);
    return (width / 4 > 1) ? $clog2(width / 4) : 1;
  endfunction

  localparam int IDX_W = idx_width(LCD_WIDTH_DEFAULT);

endpackage

// File: rtl/lcd_line_bank.sv
// Ping-pong line storage: 2-bit pixel writes into one bank, byte reads from the other.
`timescale 1ns/1ps
module lcd_line_bank
  import lcd_stream_pkg::*;
#(
  parameter int LCD_WIDTH = LCD_WIDTH_DEFAULT,
  parameter int IW        = idx_width(LCD_WIDTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [7:0]    wr_x,
  input  logic [1:0]    wr_col,
  input  logic          rd_bank,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  localparam int BPL = LCD_WIDTH / 4;

  logic [7:0] mem [2][BPL];

  // pixel 4k+j lives in bits [2j+1:2j] of byte k
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_x[IW+1:2]][{wr_x[1:0], 1'b0} +: 2] <= wr_col;
    end
  end

  assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/lcd_line_streamer.sv
// Captures LCD scanlines into a ping-pong buffer and streams line / frame packets over valid/ready.
//   state    | meaning
//   ST_IDLE  | nothing to send, out_valid low
//   ST_LHDR  | line header byte 0xA5
//   ST_LNUM  | line number byte
//   ST_LDATA | packed pixel bytes from the read bank
//   ST_FHDR  | frame marker header 0x5A
//   ST_FNUM  | frame number byte
`timescale 1ns/1ps
module lcd_line_streamer
  import lcd_stream_pkg::*;
#(
  parameter int LCD_WIDTH  = LCD_WIDTH_DEFAULT,
  parameter int LCD_HEIGHT = LCD_HEIGHT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_hblank,
  input  logic       lcd_vblank,
  input  logic       lcd_write,
  input  logic [1:0] lcd_col,
  input  logic [7:0] lcd_x,
  input  logic [7:0] lcd_y,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic [7:0] dropped_lines
);

  localparam int              BPL      = LCD_WIDTH / 4;
  localparam int              IW       = idx_width(LCD_WIDTH);
  localparam logic [8:0]      X_LIM    = 9'(LCD_WIDTH);
  localparam logic [8:0]      Y_LIM    = 9'(LCD_HEIGHT);
  localparam logic [IW-1:0]   LAST_IDX = IW'(BPL - 1);

  stream_state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [7:0]    rd_data;

  logic       hblank_d, vblank_d, hb_rise, vb_rise;
  logic       wr_ok, dirty_now, commit, drop;
  logic       wr_bank, rd_bank;
  logic       line_dirty, line_pending;
  logic       frame_pending, frame_renew;
  logic [7:0] cur_line, line_now, pend_line;
  logic [7:0] frame_cnt, frame_num, fnum_hold;
  logic       accept, release_bank, frame_done;

  assign hb_rise = lcd_hblank & ~hblank_d;
  assign vb_rise = lcd_vblank & ~vblank_d;
  assign wr_ok   = lcd_write & ({1'b0, lcd_x} < X_LIM) & ({1'b0, lcd_y} < Y_LIM);

  // a write landing on the hblank edge still belongs to the line being closed
  assign dirty_now = line_dirty | wr_ok;
  assign line_now  = line_dirty ? cur_line : lcd_y;
  assign commit    = hb_rise & dirty_now & ~line_pending;
  assign drop      = hb_rise & dirty_now & line_pending;
  assign rd_bank   = ~wr_bank;

  assign accept       = out_valid & out_ready;
  assign release_bank = accept & (state == ST_LDATA) & (idx == LAST_IDX);
  assign frame_done   = accept & (state == ST_FNUM);

  lcd_line_bank #(
    .LCD_WIDTH (LCD_WIDTH),
    .IW        (IW)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_bank (wr_bank),
    .wr_x    (lcd_x),
    .wr_col  (lcd_col),
    .rd_bank (rd_bank),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_d      <= 1'b0;
      vblank_d      <= 1'b0;
      wr_bank       <= 1'b0;
      line_dirty    <= 1'b0;
      line_pending  <= 1'b0;
      cur_line      <= '0;
      pend_line     <= '0;
      overflow      <= 1'b0;
      dropped_lines <= '0;
      frame_pending <= 1'b0;
      frame_renew   <= 1'b0;
      frame_cnt     <= '0;
      frame_num     <= '0;
      fnum_hold     <= '0;
    end else begin
      hblank_d <= lcd_hblank;
      vblank_d <= lcd_vblank;

      if (wr_ok && !line_dirty) cur_line <= lcd_y;
      if (wr_ok) line_dirty <= 1'b1;
      if (hb_rise && dirty_now) line_dirty <= 1'b0;

      if (release_bank) line_pending <= 1'b0;
      if (commit) begin
        line_pending <= 1'b1;
        wr_bank      <= ~wr_bank;
        pend_line    <= line_now;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_lines != 8'hFF) dropped_lines <= dropped_lines + 8'd1;
      end

      if (state == ST_FHDR && accept) fnum_hold <= frame_num;
      if (frame_done) begin
        frame_renew <= 1'b0;
        if (!frame_renew) frame_pending <= 1'b0;
      end
      // a newer marker arriving after the number byte is fixed must survive the FNUM handshake
      if (vb_rise) begin
        if (frame_pending && !frame_done) overflow <= 1'b1;
        frame_pending <= 1'b1;
        frame_num     <= frame_cnt;
        frame_cnt     <= frame_cnt + 8'd1;
        if ((state == ST_FNUM && !frame_done) || (state == ST_FHDR && accept)) frame_renew <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != ST_LDATA) idx <= '0;
      else if (state == ST_LDATA && accept) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b1;
    out_data  = 8'h00;
    unique case (state)
      ST_IDLE: begin
        out_valid = 1'b0;
        if (line_pending || commit) state_nx = ST_LHDR;
        else if (frame_pending || vb_rise) state_nx = ST_FHDR;
      end
      ST_LHDR: begin
        out_data = LINE_HDR;
        if (accept) state_nx = ST_LNUM;
      end
      ST_LNUM: begin
        out_data = pend_line;
        if (accept) state_nx = ST_LDATA;
      end
      ST_LDATA: begin
        out_data = rd_data;
        if (release_bank) state_nx = ST_IDLE;
      end
      ST_FHDR: begin
        out_data = FRAME_HDR;
        if (accept) state_nx = ST_FNUM;
      end
      ST_FNUM: begin
        out_data = fnum_hold;
        if (accept) state_nx = ST_IDLE;
      end
      default: begin
        out_valid = 1'b0;
        state_nx  = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_line_streamer.sv
// Self-checking bench for lcd_line_streamer: vector table, directed corner sequences and a randomized line/frame run.
`timescale 1ns/1ps
module tb_lcd_line_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_hblank, lcd_vblank, lcd_write;
  logic [1:0] lcd_col;
  logic [7:0] lcd_x, lcd_y;
  logic [7:0] out_data, dropped_lines;
  logic       out_valid, out_ready, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;   // 0 always ready, 1 toggle, 2 never, 3 random
  int fcnt_model = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [1:0] img[160];

  typedef struct {
    int         x;
    int         y;
    logic [1:0] col;
    bit         exp_pkt;
    logic [7:0] exp_line;
    logic [1:0] exp_bits;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  lcd_line_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .lcd_hblank    (lcd_hblank),
    .lcd_vblank    (lcd_vblank),
    .lcd_write     (lcd_write),
    .lcd_col       (lcd_col),
    .lcd_x         (lcd_x),
    .lcd_y         (lcd_y),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .dropped_lines (dropped_lines)
  );

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // collects accepted bytes and checks that a stalled byte is held
  initial begin
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = 8'h00;
    forever begin
      @(negedge clk);
      if (stall) begin
        n_tests++;
        if (!(out_valid === 1'b1 && out_data === held)) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h", out_valid, out_data, held);
        end
      end
      stall = out_valid && !out_ready && !reset;
      held  = out_data;
      if (out_valid && out_ready && !reset) got.push_back(out_data);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic write_px(input int x, input int y, input logic [1:0] c);
    step();
    lcd_write = 1'b1;
    lcd_x     = 8'(x);
    lcd_y     = 8'(y);
    lcd_col   = c;
  endtask

  task automatic write_line(input int y);
    for (int x = 0; x < 160; x++) write_px(x, y, img[x]);
    step();
    lcd_write = 1'b0;
  endtask

  task automatic commit_line();
    lcd_hblank = 1'b1;
    repeat (4) step();
    lcd_hblank = 1'b0;
    step();
  endtask

  task automatic vblank_pulse();
    lcd_vblank = 1'b1;
    repeat (3) step();
    lcd_vblank = 1'b0;
    step();
  endtask

  task automatic push_line(input int y);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(y));
    for (int k = 0; k < 40; k++)
      exp_q.push_back({img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]});
  endtask

  task automatic push_frame();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(fcnt_model));
    fcnt_model = (fcnt_model + 1) % 256;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (got.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_bytes: received %0d bytes, required %0d", got.size(), n);
    end
  endtask

  task automatic compare_stream(input string name);
    int first;
    int lim;
    first = -1;
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (got[i] !== exp_q[i] && first < 0) first = i;
    n_tests++;
    if (first >= 0) begin
      n_fail++;
      $display("FAIL %s: byte %0d is %02h, expected %02h (len %0d vs %0d)",
               name, first, got[first], exp_q[first], got.size(), exp_q.size());
    end else if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s: stream length %0d, expected %0d", name, got.size(), exp_q.size());
    end
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    step();
    reset      = 1'b1;
    lcd_write  = 1'b0;
    lcd_hblank = 1'b0;
    lcd_vblank = 1'b0;
    repeat (2) step();
    reset      = 1'b0;
    fcnt_model = 0;
    step();
    clear_q();
  endtask

  initial begin
    vecs[0] = '{3,   5,   2'd2, 1'b1, 8'd5,   2'd2};
    vecs[1] = '{0,   0,   2'd1, 1'b1, 8'd0,   2'd1};
    vecs[2] = '{159, 143, 2'd3, 1'b1, 8'd143, 2'd3};
    vecs[3] = '{160, 10,  2'd1, 1'b0, 8'd0,   2'd0};
    vecs[4] = '{200, 10,  2'd1, 1'b0, 8'd0,   2'd0};
    vecs[5] = '{10,  144, 2'd2, 1'b0, 8'd0,   2'd0};
    vecs[6] = '{10,  150, 2'd1, 1'b0, 8'd0,   2'd0};
    vecs[7] = '{255, 255, 2'd3, 1'b0, 8'd0,   2'd0};
    vecs[8] = '{77,  100, 2'd2, 1'b1, 8'd100, 2'd2};
    vecs[9] = '{158, 7,   2'd1, 1'b1, 8'd7,   2'd1};

    reset = 1'b1;
    lcd_hblank = 1'b0; lcd_vblank = 1'b0; lcd_write = 1'b0;
    lcd_col = 2'd0; lcd_x = 8'd0; lcd_y = 8'd0;
    repeat (3) step();
    @(negedge clk);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_data", {24'd0, out_data}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_dropped", {24'd0, dropped_lines}, 32'd0);
    reset = 1'b0;
    clear_q();

    // single line with hblank latency
    for (int x = 0; x < 160; x++) img[x] = 2'(x % 4);
    write_line(5);
    lcd_hblank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_hdr", {24'd0, out_data}, 32'hA5);
    push_line(5);
    wait_bytes(42, 200);
    lcd_hblank = 1'b0;
    compare_stream("single_line");
    @(posedge clk);
    @(negedge clk);
    check("single_valid_drop", {31'd0, out_valid}, 32'd0);
    check("single_overflow", {31'd0, overflow}, 32'd0);

    // backpressure with toggling ready
    clear_q();
    ready_mode = 1;
    write_line(5);
    commit_line();
    push_line(5);
    wait_bytes(42, 400);
    ready_mode = 0;
    repeat (10) step();
    compare_stream("backpressure");

    // overflow: second line dropped while the first is still held
    clear_q();
    ready_mode = 2;
    for (int x = 0; x < 160; x++) img[x] = 2'((x / 4) % 4);
    write_line(0);
    commit_line();
    push_line(0);
    for (int x = 0; x < 160; x++) img[x] = 2'($urandom);
    write_line(1);
    commit_line();
    check("ovf_dropped", {24'd0, dropped_lines}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    ready_mode = 0;
    wait_bytes(42, 300);
    repeat (60) step();
    compare_stream("overflow_pkt");
    do_reset();

    // table of single-pixel lines, including out-of-range writes
    for (int i = 0; i < 10; i++) begin
      got.delete();
      write_px(vecs[i].x, vecs[i].y, vecs[i].col);
      step();
      lcd_write = 1'b0;
      commit_line();
      if (vecs[i].exp_pkt) begin
        wait_bytes(42, 200);
        repeat (3) step();
        check($sformatf("vec%0d_len", i), got.size(), 32'd42);
        if (got.size() == 42) begin
          logic [7:0] b;
          logic [1:0] lane;
          b = got[2 + vecs[i].x / 4];
          lane = 2'(b >> (2 * (vecs[i].x % 4)));
          check($sformatf("vec%0d_hdr", i), {24'd0, got[0]}, 32'hA5);
          check($sformatf("vec%0d_line", i), {24'd0, got[1]}, {24'd0, vecs[i].exp_line});
          check($sformatf("vec%0d_pixel", i), {30'd0, lane}, {30'd0, vecs[i].exp_bits});
        end
      end else begin
        repeat (50) step();
        check($sformatf("vec%0d_nopkt", i), got.size(), 32'd0);
      end
    end
    check("table_overflow", {31'd0, overflow}, 32'd0);

    // full frame followed by frame markers
    clear_q();
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) img[x] = 2'(x + y);
      write_line(y);
      commit_line();
      push_line(y);
    end
    vblank_pulse();
    push_frame();
    wait_bytes(exp_q.size(), 2000);
    repeat (5) step();
    compare_stream("frame_stream");
    check("frame_overflow", {31'd0, overflow}, 32'd0);

    clear_q();
    vblank_pulse();
    push_frame();
    wait_bytes(2, 100);
    repeat (5) step();
    compare_stream("frame_next");

    clear_q();
    ready_mode = 2;
    repeat (2) step();
    vblank_pulse();
    vblank_pulse();
    fcnt_model = (fcnt_model + 1) % 256;
    push_frame();
    check("merge_overflow", {31'd0, overflow}, 32'd1);
    check("merge_dropped", {24'd0, dropped_lines}, 32'd0);
    ready_mode = 0;
    wait_bytes(2, 100);
    repeat (20) step();
    compare_stream("frame_merge");

    // reset in the middle of a line packet
    clear_q();
    for (int x = 0; x < 160; x++) img[x] = 2'(x % 4);
    write_line(9);
    commit_line();
    wait_bytes(12, 100);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    check("midrst_dropped", {24'd0, dropped_lines}, 32'd0);
    reset = 1'b0;
    fcnt_model = 0;
    step();
    clear_q();
    for (int x = 0; x < 160; x++) img[x] = 2'($urandom);
    write_line(9);
    commit_line();
    push_line(9);
    wait_bytes(42, 200);
    repeat (5) step();
    compare_stream("after_reset");

    // randomized lines with junk writes, overrides, frame markers and random ready
    clear_q();
    ready_mode = 3;
    for (int it = 0; it < 10; it++) begin
      int y;
      y = $urandom_range(0, 143);
      for (int x = 0; x < 160; x++) img[x] = 2'($urandom);
      for (int x = 0; x < 160; x++) begin
        if ($urandom_range(0, 7) == 0) write_px($urandom_range(160, 255), y, 2'($urandom));
        if ($urandom_range(0, 7) == 0) write_px(x, $urandom_range(144, 255), 2'($urandom));
        if ($urandom_range(0, 7) == 0) write_px(x, y, ~img[x]);
        write_px(x, y, img[x]);
      end
      step();
      lcd_write = 1'b0;
      commit_line();
      push_line(y);
      if ($urandom_range(0, 2) == 0) begin
        vblank_pulse();
        push_frame();
      end
      wait_bytes(exp_q.size(), 1000);
    end
    ready_mode = 0;
    repeat (10) step();
    compare_stream("random_stream");
    check("random_overflow", {31'd0, overflow}, 32'd0);
    check("random_dropped", {24'd0, dropped_lines}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_line_streamer.md
Name: lcd_line_streamer

Overview:
- Sits directly downstream of the Game Boy core's LCD pixel interface (lcd_write/lcd_col/lcd_x/lcd_y/lcd_hblank/lcd_vblank).
- Captures each scanline into a ping-pong line buffer.
- Streams each completed line as a byte packet over a valid/ready interface, for a UART/SPI/PMOD exporter.
- Emits a frame marker packet on every vblank start.

Parameters:
- LCD_WIDTH, 160, pixels per line. Must be a multiple of 4.
- LCD_HEIGHT, 144, lines per frame. Pixels with y >= LCD_HEIGHT are ignored.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- lcd_hblank  in  1  core hblank level.
- lcd_vblank  in  1  core vblank level.
- lcd_write  in  1  pixel strobe, one pixel per cycle.
- lcd_col  in  2  pixel shade.
- lcd_x  in  8  pixel column.
- lcd_y  in  8  pixel line.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte.
- overflow  out  1  sticky error flag. Cleared only by reset.
- dropped_lines  out  8  saturating count of dropped lines.

Behaviour:
- Reset: out_valid=0, out_data=0, overflow=0, dropped_lines=0, frame counter=0, FSM=IDLE, both banks free, all pending flags cleared. Bank contents are don't-care.
- Storage: two banks, each LCD_WIDTH/4 bytes. Byte k holds pixels 4k..4k+3, with pixel 4k in bits[1:0] and pixel 4k+3 in bits[7:6].
- Write side:
  - When lcd_write=1, x < LCD_WIDTH and y < LCD_HEIGHT, write lcd_col to the write bank at pixel x.
  - The first accepted write of a line latches lcd_y as the line number and sets line_dirty.
  - Out-of-range pixels are ignored entirely.
  - Repeated writes to the same x: last write wins.
  - Unwritten pixels keep their stale contents.
- hblank rise: detected as lcd_hblank=1 while the registered hblank_d=0.
  - A lcd_write in the same cycle belongs to the line being committed.
  - If line_dirty and the read bank is free: swap banks, set line_pending, clear line_dirty.
  - If line_dirty and the read bank is busy: drop the line, set overflow=1, increment dropped_lines (saturates at 255), clear line_dirty. The write bank is reused.
  - If not line_dirty: no action.
- vblank rise (lcd_vblank=1, vblank_d=0):
  - Set frame_pending and latch frame_num = frame counter; the counter then increments (8-bit, wraps 255->0).
  - If frame_pending is already set: keep a single pending marker, update it to the newest frame_num, set overflow=1. dropped_lines is unchanged.
- Output FSM states: IDLE, LHDR, LNUM, LDATA, FHDR, FNUM.
  - IDLE: if line_pending go to LHDR; else if frame_pending go to FHDR. A line always has priority over a frame.
  - LHDR: out_data=8'hA5.
  - LNUM: out_data=line number.
  - LDATA: out_data=read-bank byte idx. idx runs 0..LCD_WIDTH/4-1.
  - After the last data byte: release the read bank, clear line_pending, go to IDLE.
  - FHDR: out_data=8'h5A.
  - FNUM: out_data=frame_num, then clear frame_pending and go to IDLE.
  - A state advances only on out_valid & out_ready.
  - out_valid=1 in every state except IDLE.
  - out_data must not change while out_valid=1 and out_ready=0.
- Latency: with out_ready=1, 0xA5 appears with out_valid high in the cycle after the commit edge.
  - A line packet takes 2+LCD_WIDTH/4 cycles (42 at default).
  - Back-to-back packets have one IDLE cycle between them.
- Reset mid-packet: the stream aborts at once with out_valid=0 the next cycle. No partial resume.

Decomposition:
- Package lcd_stream_pkg holds:
  - FSM state enum
  - LINE_HDR=8'hA5
  - FRAME_HDR=8'h5A
  - BYTES_PER_LINE=LCD_WIDTH/4
  - Width of the byte index counter
- One sub-module, lcd_line_bank:
  - Two banks with the pixel-granular write port and byte read port.
  - Bank select inputs.
  - Combinational read mux.
- Top level holds the edge detectors, pending flags, counters and output FSM.

Test Plan:
- Single line: write y=5, x=0..159, col=x%4, then raise hblank, with out_ready=1 -> stream 0xA5, 0x05, then 40 bytes of 0xE4; out_valid then drops; overflow=0.
- Backpressure: same line with out_ready toggling 1/0 every cycle -> identical 42 bytes; out_data held stable during every stall cycle; no duplicated or skipped bytes.
- Overflow: out_ready=0; commit line 0, then fully write line 1 and raise hblank -> dropped_lines=1, overflow=1; after out_ready=1, only the line 0 packet is emitted.
- Frame markers: lines 0..143, then vblank, out_ready=1 -> line 143 packet, then 0x5A, 0x00; the next frame's vblank gives 0x5A, 0x01. A second vblank while the first marker is still pending gives one marker with the latest number and overflow=1.
- Filtering: writes at x=200 or y=150, then hblank -> no packet; a single write at x=3 col=2 -> packet whose byte 0 has bits[7:6]=2'b10.
- Reset mid-stream: assert reset after 10 data bytes -> out_valid=0 next cycle, dropped_lines=0, overflow=0; a following full line streams correctly from 0xA5.
